// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Execute-stage forwarding, load-use/branch stall and flush, MUL/DIV sequencing.
// Define HAZARD_MULDIV_EN to build the MUL/DIV sequencer; without it the MD outputs are tied low.
module hazard_ctrl #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       ResultSrcE0,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MdReqE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdStartE,
    output logic       MdDoneE
);
    logic w_lw_stall, w_md_stall, w_md_start, w_md_done;
    always_comb begin
        ForwardAE = reset ? 2'b00
                  : (RegWriteM && RdM == Rs1E && Rs1E != 5'd0) ? 2'b10
                  : (RegWriteW && RdW == Rs1E && Rs1E != 5'd0) ? 2'b01 : 2'b00;
        ForwardBE = reset ? 2'b00
                  : (RegWriteM && RdM == Rs2E && Rs2E != 5'd0) ? 2'b10
                  : (RegWriteW && RdW == Rs2E && Rs2E != 5'd0) ? 2'b01 : 2'b00;
        w_lw_stall = !reset && ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        StallF = w_lw_stall || w_md_stall;
        StallD = w_lw_stall || w_md_stall;
        FlushD = !reset && PCSrcE && !w_md_stall;
        FlushE = !reset && (w_lw_stall || PCSrcE) && !w_md_stall;
    end
`ifdef HAZARD_MULDIV_EN
    localparam int CW = $clog2(MD_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state;
    logic [CW-1:0] r_cnt;
    // DONE always returns to IDLE: MdReqE is still high for the departing op there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (MdReqE) begin
                    r_state <= BUSY;
                    r_cnt   <= CW'(MD_CYCLES - 1);
                end
                BUSY: if (r_cnt == '0) r_state <= DONE;
                      else r_cnt <= r_cnt - CW'(1);
                default: r_state <= IDLE;
            endcase
        end
    end
    assign w_md_start = !reset && r_state == IDLE && MdReqE;
    assign w_md_stall = w_md_start || (!reset && r_state == BUSY);
    assign w_md_done  = !reset && r_state == DONE;
`else
    logic w_unused;
    assign w_unused   = ^{clk, MdReqE};
    assign w_md_start = 1'b0;
    assign w_md_stall = 1'b0;
    assign w_md_done  = 1'b0;
`endif
    assign StallE   = w_md_stall;
    assign FlushM   = w_md_stall;
    assign MdStartE = w_md_start;
    assign MdDoneE  = w_md_done;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, MUL/DIV corner sequences and randomized checks against a cycle-count model.
module tb_hazard_ctrl;
    localparam int MD = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MDEN = 1'b1;
`else
    localparam bit MDEN = 1'b0;
`endif
    localparam logic [11:0] ST  = 12'h0E4;
    localparam logic [11:0] MS  = 12'h002;
    localparam logic [11:0] MDN = 12'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MdReqE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStartE, MdDoneE;

    int checks = 0;
    int failures = 0;
    int md_t = -1;

    hazard_ctrl #(.MD_CYCLES(MD)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MdReqE(MdReqE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE)
    );

    typedef struct {
        logic rst, ld, rwm, rww, pcs, req;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 0 && RegWriteM && RdM == rs) return 2'b10;
        if (rs != 0 && RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // md_t counts cycles since the op entered Execute (-1 = no op in flight)
    function automatic logic [11:0] model();
        logic lw, start, busy, done;
        if (reset) return 12'h000;
        lw    = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        start = MDEN && md_t < 0 && MdReqE;
        busy  = start || (md_t >= 1 && md_t <= MD);
        done  = md_t == MD + 1;
        return {fwd(Rs1E), fwd(Rs2E), lw || busy, lw || busy, busy,
                PCSrcE && !busy, (lw || PCSrcE) && !busy, busy, start, done};
    endfunction

    task automatic step(input logic [11:0] exp, input string nm);
        logic [11:0] act;
        @(negedge clk);
        act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdStartE, MdDoneE};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
        if (reset) md_t = -1;
        else if (md_t >= 0) md_t = (md_t == MD + 1) ? -1 : md_t + 1;
        else if (MDEN && MdReqE) md_t = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 0; ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MdReqE = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    endtask

    initial begin
        vecs = '{
            '{0,0,1,1,0,0, 0,0,5,0,0,5,5, 12'b10_00_00000000},
            '{0,0,0,1,0,0, 0,0,5,0,0,5,5, 12'b01_00_00000000},
            '{0,0,1,1,0,0, 0,0,0,0,0,5,5, 12'b00_00_00000000},
            '{0,0,0,1,0,0, 0,0,0,9,0,9,9, 12'b00_01_00000000},
            '{0,0,1,1,0,0, 0,0,0,9,0,9,3, 12'b00_10_00000000},
            '{0,1,1,0,0,0, 0,7,0,4,7,4,0, 12'b00_10_11001000},
            '{0,1,0,0,0,0, 0,0,0,0,0,0,0, 12'b00_00_00000000},
            '{0,0,0,0,0,0, 7,0,0,0,7,0,0, 12'b00_00_00000000},
            '{0,0,0,0,1,0, 0,0,0,0,0,0,0, 12'b00_00_00011000},
            '{0,1,0,0,1,0, 3,0,0,0,3,0,0, 12'b00_00_11011000},
            '{1,1,1,1,1,0, 3,0,5,5,3,5,5, 12'b00_00_00000000},
            '{0,0,1,1,0,0, 0,0,5,0,0,5,5, 12'b10_00_00000000}
        };
        clr();
        reset = 1; MdReqE = 1; PCSrcE = 1; RegWriteM = 1; RdM = 2; Rs1E = 2;
        step(12'h000, "reset_hold");
        clr();
        foreach (vecs[i]) begin
            reset = vecs[i].rst; ResultSrcE0 = vecs[i].ld; RegWriteM = vecs[i].rwm;
            RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pcs; MdReqE = vecs[i].req;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            step(vecs[i].exp, $sformatf("vec%0d", i));
        end
        clr();
`ifdef HAZARD_MULDIV_EN
        MdReqE = 1;
        for (int k = 0; k <= MD + 1; k++)
            step(k == 0 ? (ST | MS) : (k <= MD ? ST : MDN), $sformatf("md1_c%0d", k));
        RdE = 3; Rs1D = 3;
        for (int k = 0; k <= MD + 1; k++) begin
            ResultSrcE0 = (k == 2);
            step(k == 0 ? (ST | MS) : (k <= MD ? ST : MDN), $sformatf("md2_c%0d", k));
        end
        clr();
        step(12'h000, "md_idle");
        MdReqE = 1;
        step(ST | MS, "rb_c0");
        step(ST, "rb_c1");
        reset = 1; PCSrcE = 1;
        step(12'h000, "rb_reset");
        clr();
        for (int k = 0; k < MD + 3; k++) step(12'h000, $sformatf("rb_after%0d", k));
`else
        MdReqE = 1;
        step(12'h000, "mdoff_req");
        ResultSrcE0 = 1; RdE = 6; Rs2D = 6;
        step(12'h0C8, "mdoff_lw");
        ResultSrcE0 = 0; PCSrcE = 1;
        step(12'h018, "mdoff_br");
        clr();
`endif
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 24) == 0);
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
            ResultSrcE0 = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1)); PCSrcE = ($urandom_range(0, 3) == 0);
            MdReqE = ($urandom_range(0, 3) == 0);
            step(model(), "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
